// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the hold-based round-robin scheduler family.
// Helpers operate on the widest supported requester vector; callers cast to their own width.
package rr_sched_pkg;

  localparam int MAX_N   = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDW-1:0] idx);
    logic [MAX_N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Walk offsets from far to near so the nearest set bit after ptr is the last one written.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0]   req,
                                    input logic [MAX_IDW-1:0] ptr,
                                    input int                 n);
    pick_t res;
    int    cand;
    res = '0;
    for (int off = MAX_N; off >= 1; off--) begin
      if (off <= n) begin
        cand = int'(ptr) + off;
        if (cand >= n) begin
          cand = cand - n;
        end
        if (req[cand[MAX_IDW-1:0]]) begin
          res.valid = 1'b1;
          res.idx   = cand[MAX_IDW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: first set request bit at or after (ptr+1) mod N, with wrap.
module rr_prio_pick
  import rr_sched_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           valid_o,
  output logic [IDW-1:0] idx_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_N'(req_i), MAX_IDW'(ptr_i), N);
    valid_o = pick.valid;
    idx_o   = IDW'(pick.idx);
  end

endmodule

// File: rtl/rr_hold_scheduler.sv
// Round-robin scheduler that holds a grant for a whole transaction, with a one-cycle
// turnaround gap after every release and timeout preemption when others are waiting.
module rr_hold_scheduler
  import rr_sched_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic           DONE,
  output logic [N-1:0]   GRANT,
  output logic [IDW-1:0] GRANT_ID,
  output logic           GRANT_VALID,
  output logic           PREEMPT
);

  localparam int              HCW        = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0]  HOLD_LIMIT = HCW'(MAX_HOLD - 1);

  sched_state_t   state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grantId_q, grantId_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] holdCnt_q, holdCnt_d;
  logic           grantValid_q, grantValid_d;
  logic           preempt_q, preempt_d;

  logic           pickValid;
  logic [IDW-1:0] pickIdx;
  logic           ownerReq;
  logic           othersWaiting;
  logic           timeout;
  logic           releaseNow;

  rr_prio_pick #(.N(N)) u_pick (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .valid_o (pickValid),
    .idx_o   (pickIdx)
  );

  assign ownerReq      = REQ[grantId_q];
  assign othersWaiting = |(REQ & ~grant_q);
  assign timeout       = (holdCnt_q == HOLD_LIMIT) && othersWaiting;
  assign releaseNow    = DONE || !ownerReq || timeout;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grantId_q    <= '0;
      grantValid_q <= 1'b0;
      preempt_q    <= 1'b0;
      holdCnt_q    <= '0;
      ptr_q        <= IDW'(N - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grantId_q    <= grantId_d;
      grantValid_q <= grantValid_d;
      preempt_q    <= preempt_d;
      holdCnt_q    <= holdCnt_d;
      ptr_q        <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pickValid) state_d = BUSY;
      BUSY:    if (releaseNow) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE outranks the timeout, so PREEMPT only fires when the owner is still mid-transaction.
  always_comb begin
    grant_d   = grant_q;
    grantId_d = grantId_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d   = N'(onehot(MAX_IDW'(pickIdx)));
          grantId_d = pickIdx;
          ptr_d     = pickIdx;
          holdCnt_d = '0;
        end
      end
      BUSY: begin
        if (releaseNow) begin
          grant_d   = '0;
          grantId_d = '0;
          preempt_d = !DONE && ownerReq && timeout;
        end else if (holdCnt_q != HOLD_LIMIT) begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end
      default: begin
        grant_d   = '0;
        grantId_d = '0;
      end
    endcase
    grantValid_d = |grant_d;
  end

  assign GRANT       = grant_q;
  assign GRANT_ID    = grantId_q;
  assign GRANT_VALID = grantValid_q;
  assign PREEMPT     = preempt_q;

endmodule

// File: tb/tb_rr_hold_scheduler.sv
// Self-checking bench: directed vector table, hand sequences for hold/preempt corners,
// and randomized traffic compared against a transaction-level reference model.
module tb_rr_hold_scheduler;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = $clog2(N);

  logic           clk = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic           DONE;
  logic [N-1:0]   GRANT;
  logic [IDW-1:0] GRANT_ID;
  logic           GRANT_VALID;
  logic           PREEMPT;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: who owns the resource, who won last, edges since the grant, pending turnaround.
  int mOwner;
  int mLast;
  int mAge;
  bit mGap;
  bit mPreempt;

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] expGrant;
    logic         expPreempt;
  } vec_t;

  vec_t vecs[$];

  rr_hold_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .RST         (RST),
    .REQ         (REQ),
    .DONE        (DONE),
    .GRANT       (GRANT),
    .GRANT_ID    (GRANT_ID),
    .GRANT_VALID (GRANT_VALID),
    .PREEMPT     (PREEMPT)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input logic [N-1:0] req, input logic done, input logic rst);
    bit others;
    bit found;
    int cand;
    mPreempt = 1'b0;
    if (rst) begin
      mOwner = -1;
      mLast  = N - 1;
      mAge   = 0;
      mGap   = 1'b0;
    end else if (mOwner >= 0) begin
      others = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (i != mOwner && req[i]) others = 1'b1;
      end
      if (done || !req[mOwner] || (mAge >= MAX_HOLD - 1 && others)) begin
        mPreempt = !done && req[mOwner];
        mOwner   = -1;
        mGap     = 1'b1;
      end else begin
        mAge++;
      end
    end else if (mGap) begin
      mGap = 1'b0;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        cand = (mLast + k) % N;
        if (!found && req[cand]) begin
          found  = 1'b1;
          mOwner = cand;
          mLast  = cand;
          mAge   = 0;
        end
      end
    end
  endtask

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic done, input logic rst);
    REQ  = req;
    DONE = done;
    RST  = rst;
    modelStep(req, done, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    logic [N-1:0]   expGrant;
    logic [IDW-1:0] expId;
    expGrant = '0;
    expId    = '0;
    if (mOwner >= 0) begin
      expGrant[mOwner] = 1'b1;
      expId            = IDW'(mOwner);
    end
    checkField("GRANT", 32'(GRANT), 32'(expGrant));
    checkField("GRANT_ID", 32'(GRANT_ID), 32'(expId));
    checkField("GRANT_VALID", 32'(GRANT_VALID), 32'(mOwner >= 0));
    checkField("PREEMPT", 32'(PREEMPT), 32'(mPreempt));
  endtask

  task automatic step(input logic [N-1:0] req, input logic done, input logic rst);
    applyStimulus(req, done, rst);
    checkOutput();
  endtask

  task automatic addVec(input logic [N-1:0] req, input logic done,
                        input logic [N-1:0] expGrant, input logic expPreempt);
    vec_t v;
    v.req        = req;
    v.done       = done;
    v.expGrant   = expGrant;
    v.expPreempt = expPreempt;
    vecs.push_back(v);
  endtask

  initial begin
    int           preemptStep;
    int           preemptSeen;
    logic [N-1:0] rndReq;

    // Rotation with everyone requesting: three grant cycles, DONE, one gap, one idle.
    for (int g = 0; g < N; g++) begin
      for (int c = 0; c < 3; c++) addVec(4'b1111, 1'b0, N'(1 << g), 1'b0);
      addVec(4'b1111, 1'b1, 4'b0000, 1'b0);
      addVec(4'b1111, 1'b0, 4'b0000, 1'b0);
    end
    addVec(4'b1111, 1'b0, 4'b0001, 1'b0);

    step('0, 1'b0, 1'b1);
    checkField("resetGrant", 32'(GRANT), 32'd0);
    checkField("resetValid", 32'(GRANT_VALID), 32'd0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].done, 1'b0);
      checkField("vecGrant", 32'(GRANT), 32'(vecs[i].expGrant));
      checkField("vecPreempt", 32'(PREEMPT), 32'(vecs[i].expPreempt));
      checkOutput();
    end

    // Lone owner never preempted; a late foreign request preempts on the very next edge.
    step('0, 1'b0, 1'b1);
    preemptSeen = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      checkField("loneGrant", 32'(GRANT), 32'(4'b0100));
      if (PREEMPT) preemptSeen++;
    end
    checkField("lonePreemptCount", 32'(preemptSeen), 32'd0);
    step(4'b0101, 1'b0, 1'b0);
    checkField("lateForeignPreempt", 32'(PREEMPT), 32'd1);

    // Timeout preemption of owner 0 once requester 2 is waiting.
    step('0, 1'b0, 1'b1);
    preemptStep = 0;
    for (int i = 1; i <= 11; i++) begin
      step((i <= 3) ? 4'b0001 : 4'b0101, 1'b0, 1'b0);
      if (PREEMPT) preemptStep = i;
    end
    checkField("preemptStep", 32'(preemptStep), 32'd9);
    checkField("preemptRegrant", 32'(GRANT), 32'(4'b0100));

    // DONE on the timeout edge releases without PREEMPT.
    step('0, 1'b0, 1'b1);
    preemptSeen = 0;
    for (int i = 1; i <= 11; i++) begin
      step(4'b0011, i == 9, 1'b0);
      if (PREEMPT) preemptSeen++;
    end
    checkField("doneWinsPreempt", 32'(preemptSeen), 32'd0);
    checkField("doneWinsGrant", 32'(GRANT), 32'(4'b0010));
    checkField("doneWinsId", 32'(GRANT_ID), 32'd1);

    // Owner 3 abandons; search wraps past 0 to requester 1.
    step('0, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    checkField("dropGrant", 32'(GRANT), 32'd0);
    checkField("dropPreempt", 32'(PREEMPT), 32'd0);
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    checkField("dropRegrant", 32'(GRANT), 32'(4'b0010));

    // Reset mid-transaction restores the pointer so requester 0 wins next.
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    checkField("midResetGrant", 32'(GRANT), 32'd0);
    checkField("midResetPreempt", 32'(PREEMPT), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    checkField("postResetGrant", 32'(GRANT), 32'(4'b0001));

    // Randomized traffic with sticky request levels against the reference model.
    step('0, 1'b0, 1'b1);
    rndReq = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) rndReq[b] = ~rndReq[b];
      end
      step(rndReq, $urandom_range(0, 5) == 0, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rr_hold_scheduler.md
Name: rr_hold_scheduler

Overview:
- Round-robin scheduler that shares one downstream resource (bus/execution unit) among N requesters.
- Unlike a plain per-cycle round-robin arbiter, it holds a grant for a multi-cycle transaction. It releases on DONE, on owner request drop, or on a hold-limit timeout when other requesters are waiting.
- Sits between the requester agents and the shared resource's mux select.

Parameters:
- N, 4, number of requesters (2..16)
- MAX_HOLD, 8, max cycles a grant is held while others wait (>=2)
- IDW, $clog2(N), width of encoded grant index (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  N  per-requester request level; must stay high for the whole transaction
- DONE  in  1  resource signals last cycle of current transaction (ignored unless BUSY)
- GRANT  out  N  one-hot grant, registered; all-zero when no owner
- GRANT_ID  out  IDW  encoded index of owner, registered; 0 when GRANT==0
- GRANT_VALID  out  1  high when GRANT!=0
- PREEMPT  out  1  one-cycle pulse, registered, when a grant is revoked by timeout

Behaviour:
- Reset (RST high at posedge), synchronous:
  - state=IDLE, GRANT=0, GRANT_ID=0, GRANT_VALID=0, PREEMPT=0, hold_cnt=0.
  - Pointer ptr=N-1, so requester 0 has first priority after reset.
  - RST mid-transaction drops the grant the next edge with no PREEMPT.
- States IDLE, BUSY, GAP; all outputs come from flops.
- Round-robin pick:
  - Search REQ starting at index (ptr+1) mod N, increasing with wrap; the first set bit wins.
  - On every new grant, ptr takes the winner index.
- IDLE:
  - If REQ!=0 at edge t, go to BUSY. GRANT/GRANT_ID/GRANT_VALID are valid from edge t (visible cycle t+1). hold_cnt=0.
  - Otherwise stay in IDLE.
- BUSY, owner index o. Release conditions are evaluated at each edge in priority order:
  1. DONE=1 -> GAP, outputs cleared.
  2. REQ[o]=0 -> GAP, outputs cleared (abandon).
  3. hold_cnt==MAX_HOLD-1 and (REQ & ~onehot(o))!=0 -> GAP, outputs cleared, PREEMPT=1 for exactly one cycle.
  4. Otherwise stay in BUSY. hold_cnt increments, saturating at MAX_HOLD-1.
- Hold limit with a lone owner:
  - If no other request is pending, the owner is never preempted and hold_cnt stays at MAX_HOLD-1.
  - A later foreign request preempts at the next edge.
- GAP:
  - Exactly one idle cycle with GRANT=0 (bus turnaround), then go to IDLE.
  - REQ is not sampled in GAP.
  - Earliest regrant occurs 2 edges after the release edge.
- Simultaneous DONE and timeout: DONE wins, so PREEMPT stays 0.
- Fairness: the owner is lowest priority on the next pick, so with all N requesting continuously, grants rotate 0,1,..,N-1,0.
- Invariants:
  - GRANT is one-hot or zero.
  - GRANT_ID matches GRANT.
  - GRANT never changes while in BUSY.
- No combinational path from REQ or DONE to any output.

Decomposition:
- Shared package rr_sched_pkg holds:
  - state enum sched_state_t {IDLE, BUSY, GAP}, 2 bits
  - function onehot(idx)
  - function rr_pick(req, ptr), returning valid plus index
- One sub-module, rr_prio_pick: combinational rotate-and-priority-encode of REQ from ptr+1. It is reusable by other arbiters.
- Top level holds the FSM, hold counter, pointer and output flops.

Test Plan:
- Reset then REQ=4'b1111 held, DONE pulsed 3 cycles after each grant:
  - GRANT sequence 0001,0010,0100,1000,0001.
  - Each grant is followed by one all-zero GAP cycle.
- REQ=4'b0100 alone for 20 cycles, DONE=0:
  - GRANT=0100 continuously.
  - hold_cnt saturates at 7; PREEMPT never asserts.
- Owner 0 held (REQ=0001), then REQ[2] rises at cycle 3, MAX_HOLD=8:
  - PREEMPT pulses on the 8th cycle of grant and GRANT goes to 0000.
  - After GAP, GRANT=0100.
- DONE and timeout on the same edge with REQ=0011, owner 0:
  - Release happens with PREEMPT=0.
  - Next GRANT=0010, GRANT_ID=1.
- Owner 3 drops REQ[3] mid-grant while REQ=0110 pending:
  - GRANT goes to 0 the next cycle, then GAP.
  - Next GRANT=0010 (search wraps from 3 to 0 to 1).
- RST asserted for 1 cycle while BUSY with owner 2:
  - GRANT=0 on the next cycle.
  - After release, REQ=1111 gives GRANT=0001 (ptr reset to N-1).
